bus_arbiter: RTL

Two-master bus arbiter in front of `bus_interconnect`. It shares the single RAM/GPIO data bus between master 0 (the `rysy_core` data port) and master 1 (a loader/DMA agent). Master 0 has fixed priority, with a starvation guard that bounds how long master 1 can wait. The block selects the owner each cycle, muxes the winner's request onto the bus, and returns read data with a one-cycle valid strobe matching the synchronous RAM read latency.

---
 rtl/bus_arbiter.sv | 81 ++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: master 0 has fixed priority, master 1 is guaranteed a
// grant after at most HOLD_MAX consecutive master-0 wins. Reads return one cycle later.
module bus_arbiter #(
    parameter int WIDTH    = 32,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic             m1_req,
    input  logic [WIDTH-1:0] m0_addr,
    input  logic [WIDTH-1:0] m1_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    input  logic [WIDTH-1:0] m1_wdata,
    input  logic [3:0]       m0_be,
    input  logic [3:0]       m1_be,
    input  logic             m0_we,
    input  logic             m1_we,
    output logic             m0_gnt,
    output logic             m1_gnt,
    output logic             m0_rvalid,
    output logic             m1_rvalid,
    output logic [WIDTH-1:0] m0_rdata,
    output logic [WIDTH-1:0] m1_rdata,
    output logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] wdata,
    output logic [3:0]       be,
    output logic             we,
    input  logic [WIDTH-1:0] rdata
);

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    logic [3:0] streak;
    logic       rd_pend;
    logic       rd_owner;
    logic       m1_turn;
    logic       m0_win;
    logic       m1_win;

    // Grants are gated by rst so nothing reaches the bus while reset is held.
    assign m1_turn = (streak >= HOLD_LIM);
    assign m0_win  = rst & m0_req & (~m1_req | ~m1_turn);
    assign m1_win  = rst & m1_req & (~m0_req | m1_turn);
    assign m0_gnt  = m0_win;
    assign m1_gnt  = m1_win;

    always_comb begin
        addr  = m0_addr;
        wdata = m0_wdata;
        be    = m0_be;
        we    = m0_win & m0_we;
        if (m1_win) begin
            addr  = m1_addr;
            wdata = m1_wdata;
            be    = m1_be;
            we    = m1_we;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak   <= 4'd0;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            if (m1_win || !m1_req)
                streak <= 4'd0;
            else if (m0_win && streak < HOLD_LIM)
                streak <= streak + 4'd1;
            rd_pend  <= (m0_win | m1_win) & ~we;
            rd_owner <= m1_win;
        end
    end

    assign m0_rvalid = rd_pend & ~rd_owner;
    assign m1_rvalid = rd_pend &  rd_owner;
    assign m0_rdata  = rdata;
    assign m1_rdata  = rdata;

endmodule
